// File: rtl/connect4_pkg.sv
// Shared Connect 4 definitions: player encodings, display colours and board geometry.
package connect4_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } player_e;

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] BLUE   = 3'b001;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] WHITE  = 3'b111;

  localparam int BOARD_W = 7;
  localparam int BOARD_H = 6;
  localparam int CELL    = 16;
  localparam int ORG_X   = 24;
  localparam int ORG_Y   = 16;
  localparam int CUR_Y   = 4;
  localparam int CUR_OFF = 4;
  localparam int CUR_SZ  = 8;
  localparam int SCR_W   = 160;
  localparam int SCR_H   = 120;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_BOARD,
    S_CUR_ERASE,
    S_CUR_DRAW,
    S_IDLE,
    S_CELL
  } state_e;

  function automatic logic [2:0] player_colour(input logic [1:0] p);
    case (p)
      P1:      return RED;
      P2:      return YELLOW;
      default: return BLACK;
    endcase
  endfunction

endpackage

// File: rtl/xy_scanner.sv
// W x H raster counter: i steps fastest, last flags the final (W-1, H-1) position.
module xy_scanner #(
  parameter int W = 16,
  parameter int H = 16
) (
  input  logic                 clk,
  input  logic                 start,
  input  logic                 enable,
  output logic [$clog2(W)-1:0] i,
  output logic [$clog2(H)-1:0] j,
  output logic                 last
);
  localparam int IW = $clog2(W);
  localparam int JW = $clog2(H);

  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic          i_end, j_end;

  assign i_end = (i_q == IW'(W - 1));
  assign j_end = (j_q == JW'(H - 1));
  assign last  = i_end & j_end;
  assign i     = i_q;
  assign j     = j_q;

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (start) begin
      i_d = '0;
      j_d = '0;
    end else if (enable) begin
      if (i_end) begin
        i_d = '0;
        j_d = j_end ? '0 : j_q + JW'(1);
      end else begin
        i_d = i_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    i_q <= i_d;
    j_q <= j_d;
  end

endmodule

// File: rtl/board_renderer.sv
// Turns Connect 4 game events into one registered VGA pixel write per clock.
import connect4_pkg::*;

module board_renderer #(
  parameter int CELL  = connect4_pkg::CELL,
  parameter int ORG_X = connect4_pkg::ORG_X,
  parameter int ORG_Y = connect4_pkg::ORG_Y,
  parameter int CUR_Y = connect4_pkg::CUR_Y
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic       clear_req,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic [2:0] upd_row,
  input  logic [2:0] upd_col,
  input  logic [1:0] upd_player,
  input  logic [2:0] cursor_col,
  output logic       busy,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot
);
  localparam int CW = $clog2(CELL);

  state_e state_q, state_d;
  logic [2:0] brd_row_q, brd_row_d, brd_col_q, brd_col_d;
  logic [2:0] drawn_col_q, drawn_col_d;
  logic [2:0] lat_row_q, lat_row_d, lat_col_q, lat_col_d;
  logic [1:0] lat_player_q, lat_player_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d, ready_q, ready_d, busy_q, busy_d;

  logic [7:0]    scr_i;
  logic [6:0]    scr_j;
  logic [CW-1:0] cell_i, cell_j;
  logic [2:0]    cur_i, cur_j;
  logic          scr_last, cell_last, cur_last;
  logic          scan_start, lat_ok, cur_ok, frame;
  logic [2:0]    cell_r, cell_c;
  logic [1:0]    cell_p;

  // Every state change (and any abort) rewinds all scanners to their origin.
  assign scan_start = Reset | clear_req | (state_d != state_q);

  xy_scanner #(.W(SCR_W), .H(SCR_H)) u_scr (
    .clk(CLOCK_50), .start(scan_start), .enable(state_q == S_CLEAR),
    .i(scr_i), .j(scr_j), .last(scr_last));

  xy_scanner #(.W(CELL), .H(CELL)) u_cell (
    .clk(CLOCK_50), .start(scan_start),
    .enable((state_q == S_BOARD) || (state_q == S_CELL)),
    .i(cell_i), .j(cell_j), .last(cell_last));

  xy_scanner #(.W(CUR_SZ), .H(CUR_SZ)) u_cur (
    .clk(CLOCK_50), .start(scan_start),
    .enable((state_q == S_CUR_ERASE) || (state_q == S_CUR_DRAW)),
    .i(cur_i), .j(cur_j), .last(cur_last));

  assign lat_ok = (lat_row_q < 3'(BOARD_H)) && (lat_col_q < 3'(BOARD_W)) &&
                  (lat_player_q != 2'b11);
  assign cur_ok = (cursor_col < 3'(BOARD_W));

  always_comb begin
    state_d      = state_q;
    brd_row_d    = '0;
    brd_col_d    = '0;
    drawn_col_d  = drawn_col_q;
    lat_row_d    = lat_row_q;
    lat_col_d    = lat_col_q;
    lat_player_d = lat_player_q;
    case (state_q)
      S_CLEAR: if (scr_last) state_d = S_BOARD;
      S_BOARD: begin
        brd_row_d = brd_row_q;
        brd_col_d = brd_col_q;
        if (cell_last) begin
          if (brd_col_q == 3'(BOARD_W - 1)) begin
            brd_col_d = '0;
            if (brd_row_q == 3'(BOARD_H - 1)) state_d = S_CUR_DRAW;
            else brd_row_d = brd_row_q + 3'd1;
          end else begin
            brd_col_d = brd_col_q + 3'd1;
          end
        end
      end
      S_CUR_ERASE: if (cur_last) state_d = S_CUR_DRAW;
      S_CUR_DRAW:  if (cur_last) state_d = S_IDLE;
      S_CELL:      if (!lat_ok || cell_last) state_d = S_IDLE;
      S_IDLE: begin
        if (ready_q) begin
          if (upd_valid) begin
            state_d      = S_CELL;
            lat_row_d    = upd_row;
            lat_col_d    = upd_col;
            lat_player_d = upd_player;
          end else if (cur_ok && (cursor_col != drawn_col_q)) begin
            state_d = S_CUR_ERASE;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
    if (clear_req) state_d = S_CLEAR;
    if ((state_d == S_CUR_DRAW) && (state_q != S_CUR_DRAW) && cur_ok)
      drawn_col_d = cursor_col;
  end

  always_comb begin
    cell_r   = (state_q == S_BOARD) ? brd_row_q : lat_row_q;
    cell_c   = (state_q == S_BOARD) ? brd_col_q : lat_col_q;
    cell_p   = (state_q == S_BOARD) ? EMPTY : lat_player_q;
    frame    = (cell_i < CW'(2)) || (cell_i > CW'(CELL - 3)) ||
               (cell_j < CW'(2)) || (cell_j > CW'(CELL - 3));
    plot_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    case (state_q)
      S_CLEAR: begin
        plot_d   = 1'b1;
        x_d      = scr_i;
        y_d      = scr_j;
        colour_d = BLACK;
      end
      S_BOARD, S_CELL: begin
        plot_d   = (state_q == S_BOARD) || lat_ok;
        x_d      = 8'(ORG_X) + 8'(CELL) * 8'(cell_c) + 8'(cell_i);
        y_d      = 7'(ORG_Y) + 7'(CELL) * 7'(cell_r) + 7'(cell_j);
        colour_d = frame ? BLUE : player_colour(cell_p);
      end
      S_CUR_ERASE, S_CUR_DRAW: begin
        plot_d   = 1'b1;
        x_d      = 8'(ORG_X) + 8'(CELL) * 8'(drawn_col_q) + 8'(CUR_OFF) + 8'(cur_i);
        y_d      = 7'(CUR_Y) + 7'(cur_j);
        colour_d = (state_q == S_CUR_DRAW) ? WHITE : BLACK;
      end
      default: ;
    endcase
    if (clear_req) plot_d = 1'b0;
    ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
    busy_d  = ~ready_d;
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q      <= S_CLEAR;
      brd_row_q    <= '0;
      brd_col_q    <= '0;
      drawn_col_q  <= 3'd3;
      lat_row_q    <= '0;
      lat_col_q    <= '0;
      lat_player_q <= '0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      brd_row_q    <= brd_row_d;
      brd_col_q    <= brd_col_d;
      drawn_col_q  <= drawn_col_d;
      lat_row_q    <= lat_row_d;
      lat_col_q    <= lat_col_d;
      lat_player_q <= lat_player_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
    end
  end

  assign upd_ready = ready_q;
  assign busy      = busy_q;
  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign plot      = plot_q;

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer: captures plotted pixels into a frame model.
module tb_board_renderer;
  import connect4_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic       Reset = 1'b1, clear_req = 1'b0, upd_valid = 1'b0;
  logic [2:0] upd_row = '0, upd_col = '0, cursor_col = 3'd3;
  logic [1:0] upd_player = '0;
  logic       upd_ready, busy, plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  always #10 CLOCK_50 = ~CLOCK_50;

  board_renderer #(.CELL(16), .ORG_X(24), .ORG_Y(16), .CUR_Y(4)) dut (
    .CLOCK_50(CLOCK_50), .Reset(Reset), .clear_req(clear_req),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_row(upd_row),
    .upd_col(upd_col), .upd_player(upd_player), .cursor_col(cursor_col),
    .busy(busy), .x(x), .y(y), .colour(colour), .plot(plot));

  typedef struct { int px; int py; logic [2:0] col; } pix_t;
  typedef struct { logic [2:0] row; logic [2:0] col; logic [1:0] pl; } upd_t;

  int checks = 0, failures = 0;
  logic [2:0] fb [0:159][0:119];
  int win_cyc, win_plots, first_x, first_y, first_c, first_cyc, last_c, last_cyc;
  int blk, wht, bxmin, bxmax, wxmin, wxmax, wymin, wymax;

  pix_t init_tab[12];
  pix_t upd_tab[4];
  pix_t mix_tab[3];
  pix_t clr_tab[5];
  upd_t bad_tab[3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_pix(input string tag, input pix_t p);
    checks++;
    if (fb[p.px][p.py] !== p.col) begin
      failures++;
      $display("FAIL %s pix(%0d,%0d) actual=%0d required=%0d", tag, p.px, p.py,
               fb[p.px][p.py], p.col);
    end
  endtask

  task automatic win_clear();
    win_cyc = 0; win_plots = 0; first_x = -1; first_y = -1; first_c = -1;
    first_cyc = -1; last_c = -1; last_cyc = -1; blk = 0; wht = 0;
    bxmin = 999; bxmax = -1; wxmin = 999; wxmax = -1; wymin = 999; wymax = -1;
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    win_cyc++;
    if (plot === 1'b1) begin
      if (x < 8'd160 && y < 7'd120) fb[int'(x)][int'(y)] = colour;
      win_plots++;
      if (win_plots == 1) begin
        first_x = int'(x); first_y = int'(y); first_c = int'(colour); first_cyc = win_cyc;
      end
      last_c = int'(colour);
      last_cyc = win_cyc;
      if (colour == BLACK) begin
        blk++;
        if (int'(x) < bxmin) bxmin = int'(x);
        if (int'(x) > bxmax) bxmax = int'(x);
      end
      if (colour == WHITE) begin
        wht++;
        if (int'(x) < wxmin) wxmin = int'(x);
        if (int'(x) > wxmax) wxmax = int'(x);
        if (int'(y) < wymin) wymin = int'(y);
        if (int'(y) > wymax) wymax = int'(y);
      end
    end
  endtask

  task automatic wait_for(input bit on_ready, input int budget, input string tag);
    bit done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      tick();
      done = on_ready ? (upd_ready === 1'b1) : (busy === 1'b0);
    end
    chk({tag, "_done"}, int'(done), 1);
  endtask

  initial begin
    init_tab = '{'{0, 0, BLACK}, '{24, 16, BLUE}, '{26, 18, BLACK}, '{76, 4, WHITE},
                 '{25, 17, BLUE}, '{39, 31, BLUE}, '{37, 29, BLACK}, '{75, 4, BLACK},
                 '{83, 11, WHITE}, '{84, 4, BLACK}, '{135, 111, BLUE}, '{159, 119, BLACK}};
    upd_tab  = '{'{26, 98, RED}, '{24, 96, BLUE}, '{37, 109, RED}, '{38, 110, BLUE}};
    mix_tab  = '{'{122, 18, YELLOW}, '{60, 4, WHITE}, '{92, 4, BLACK}};
    clr_tab  = '{'{74, 50, BLACK}, '{26, 98, BLACK}, '{60, 4, WHITE},
                 '{122, 18, BLACK}, '{76, 4, BLACK}};
    bad_tab  = '{'{3'd0, 3'd7, 2'b01}, '{3'd6, 3'd0, 2'b10}, '{3'd0, 3'd0, 2'b11}};
    for (int i = 0; i < 160; i++)
      for (int j = 0; j < 120; j++) fb[i][j] = 3'b010;

    // Reset held two cycles
    tick(); tick();
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_ready", int'(upd_ready), 0);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_colour", int'(colour), 0);

    Reset = 1'b0;
    win_clear();
    wait_for(1'b0, 31000, "init");
    chk("init_first_cyc", first_cyc, 1);
    chk("init_first_x", first_x, 0);
    chk("init_first_y", first_y, 0);
    chk("init_first_c", first_c, 0);
    chk("init_plots", win_plots, 30016);
    chk("init_ready", int'(upd_ready), 1);
    for (int k = 0; k < 12; k++) chk_pix("init", init_tab[k]);

    // Cell update row 5, col 0, P1
    upd_row = 3'd5; upd_col = 3'd0; upd_player = 2'b01; upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    chk("upd_ready_drop", int'(upd_ready), 0);
    win_clear();
    wait_for(1'b1, 400, "upd");
    chk("upd_first_cyc", first_cyc, 1);
    chk("upd_last_cyc", last_cyc, 256);
    chk("upd_plots", win_plots, 256);
    chk("upd_ready_cyc", win_cyc, 257);
    for (int k = 0; k < 4; k++) chk_pix("upd", upd_tab[k]);

    // Cursor 3 -> 4
    cursor_col = 3'd4;
    tick();
    win_clear();
    wait_for(1'b0, 300, "cur");
    chk("cur_plots", win_plots, 128);
    chk("cur_idle_cyc", win_cyc, 129);
    chk("cur_first_c", first_c, 0);
    chk("cur_last_c", last_c, 7);
    chk("cur_black", blk, 64);
    chk("cur_white", wht, 64);
    chk("cur_bxmin", bxmin, 76);
    chk("cur_bxmax", bxmax, 83);
    chk("cur_wxmin", wxmin, 92);
    chk("cur_wxmax", wxmax, 99);
    chk("cur_wymin", wymin, 4);
    chk("cur_wymax", wymax, 11);

    // Out-of-range updates are accepted without plotting
    for (int k = 0; k < 3; k++) begin
      upd_row = bad_tab[k].row; upd_col = bad_tab[k].col; upd_player = bad_tab[k].pl;
      upd_valid = 1'b1;
      tick();
      upd_valid = 1'b0;
      win_clear();
      wait_for(1'b1, 20, "bad");
      chk("bad_ready_cyc", win_cyc, 2);
      chk("bad_plots", win_plots, 0);
    end

    // Update and cursor change together: cell first, then cursor
    upd_row = 3'd0; upd_col = 3'd6; upd_player = 2'b10; upd_valid = 1'b1;
    cursor_col = 3'd2;
    tick();
    upd_valid = 1'b0;
    win_clear();
    repeat (400) tick();
    chk("mix_first_cyc", first_cyc, 1);
    chk("mix_first_c", first_c, 1);
    chk("mix_plots", win_plots, 384);
    chk("mix_last_cyc", last_cyc, 386);
    chk("mix_last_c", last_c, 7);
    chk("mix_wxmin", wxmin, 60);
    chk("mix_idle", int'(busy), 0);
    for (int k = 0; k < 3; k++) chk_pix("mix", mix_tab[k]);

    // clear_req mid-CELL aborts and redraws everything
    upd_row = 3'd2; upd_col = 3'd3; upd_player = 2'b01; upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    repeat (50) tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("clr_abort_plot", int'(plot), 0);
    win_clear();
    wait_for(1'b0, 31000, "clr");
    chk("clr_first_cyc", first_cyc, 1);
    chk("clr_first_x", first_x, 0);
    chk("clr_first_y", first_y, 0);
    chk("clr_first_c", first_c, 0);
    chk("clr_plots", win_plots, 30016);
    for (int k = 0; k < 5; k++) chk_pix("clr", clr_tab[k]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/board_renderer.md
# board_renderer

Downstream display stage of the Connect 4 game logic. Converts game events into pixel writes for the 160x120, 3-bit-colour VGA adapter:
- one cell update per placed token;
- the cursor marker position from the current-column counter;
- a full board redraw after reset or on a new-game request.

It emits one pixel per clock and handshakes cell updates so the game logic never drops a placement.

## Interface
Parameters:
- CELL, 16: cell edge in pixels; the scanner and all offsets are sized for 16.
- ORG_X, 24: x of the board's left edge.
- ORG_Y, 16: y of the board's top edge.
- CUR_Y, 4: y of the cursor strip's top edge.

Ports:
- CLOCK_50  in  1  system clock. One clock; all logic is on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- clear_req  in  1  single-cycle pulse that requests a full redraw (new game).
- upd_valid  in  1  cell update request.
- upd_ready  out  1  high only in IDLE. An update is accepted on any cycle where valid&ready.
- upd_row  in  3  row 0..5, where row 0 is the top row (board index row*7+col).
- upd_col  in  3  column 0..6.
- upd_player  in  2  00 = empty, 01 = P1, 10 = P2.
- cursor_col  in  3  current column, 0..6.
- busy  out  1  high in every state except IDLE.
- x  out  8  pixel x.
- y  out  7  pixel y.
- colour  out  3  pixel colour, RGB.
- plot  out  1  write strobe; x, y and colour are valid when plot is high.

## Operation
Colours:
- BLUE 001: cell frame.
- BLACK 000: empty cell, screen background.
- RED 100: P1.
- YELLOW 110: P2.
- WHITE 111: cursor.

Cell (r,c):
- Occupies x = ORG_X+16c+i and y = ORG_Y+16r+j, for i, j in 0..15.
- A pixel is BLUE if i or j is in {0,1,14,15}; otherwise it takes the player colour.

Cursor:
- 8x8 block at x = ORG_X+16c+4+i, y = CUR_Y+j, for i, j in 0..7.

Scan order everywhere: i fastest, then j; cells are visited row-major.

States:
- CLEAR: plots all 19200 pixels BLACK in raster order (x fastest), then goes to BOARD.
- BOARD: draws all 42 cells as empty, then goes to CUR_DRAW.
- CUR_ERASE: draws the cursor block BLACK at drawn_col, then goes to CUR_DRAW.
- CUR_DRAW: latches drawn_col <= cursor_col at entry, draws WHITE at drawn_col, then goes to IDLE.
- IDLE: plot = 0. Priority order: clear_req > upd_valid > (cursor_col != drawn_col).
  - clear_req → CLEAR.
  - Accepted update → CELL.
  - Cursor change → CUR_ERASE.
- CELL: draws the latched row/col/player, then goes to IDLE.

Boundary rules:
- clear_req in any state aborts the current draw; the next state is CLEAR and the pixel counters restart at 0. The latched update is discarded.
- An update with row > 5, col > 6, or player = 11 is accepted (ready completes) but no pixels are plotted; return to IDLE on the next cycle.
- cursor_col > 6 is treated as no change (no redraw) until it is back in range.
- cursor_col changes while a draw is in progress are sampled only in IDLE. Multiple intermediate moves collapse into a single erase/draw pair.
- upd_valid held during CLEAR or BOARD waits. The request stays pending with its fields stable.

## Timing
- Reset: plot = 0, x = 0, y = 0, colour = 000, upd_ready = 0, busy = 1, drawn_col = 3. The state is CLEAR, and the first plot occurs on the cycle after Reset deasserts.
- Outputs are registered, one pixel per cycle, and plot stays high throughout every drawing state.
- Init sequence: 19200 + 42·256 + 64 = 30016 plot cycles, then IDLE.
- Update accepted at edge T: the first plot is visible after T+1, the last after T+256, and upd_ready is high after T+257.
- Cursor move seen in IDLE at T: 128 plot cycles (64 erase, then 64 draw), and IDLE again after T+129.
- Reset mid-operation: takes effect at the next edge regardless of state.

## Structure
Shared package connect4_pkg holds:
- player encodings (EMPTY, P1, P2), which are also used by the game logic;
- colour constants;
- BOARD_W = 7, BOARD_H = 6, CELL, ORG_X, ORG_Y, CUR_Y.

Sub-module xy_scanner (parameters W, H):
- start, enable → local i, j, last.
- Reused by CLEAR (160x120), BOARD/CELL (16x16) and cursor (8x8).

A separate cell counter 0..41 steps rows and columns in BOARD.

## Test plan
- Reset held 2 cycles, then released → first plot (0,0,BLACK). Exactly 30016 plots, then busy = 0. Pixel (24,16) is BLUE, (26,18) is BLACK, and cursor pixel (76,4) is WHITE.
- In IDLE, upd row 5, col 0, player 01 → 256 plots. (26,98) is RED, (24,96) is BLUE, upd_ready returns after 257 cycles.
- cursor_col 3→4 in IDLE → 64 BLACK plots at x 76..83, then 64 WHITE plots at x 92..99, y 4..11.
- upd_valid with col = 7 → accepted, zero plots, upd_ready high again 2 cycles after acceptance.
- clear_req pulsed mid-CELL → the next plot is (0,0,BLACK), followed by a complete 30016-plot redraw.
- upd_valid and a cursor change are both present in IDLE → the cell draws first, then the cursor erase/draw follows.
